id_ex_stage: RTL

//  ID->EX pipeline stage that feeds the ALU. Registers decoded operands and control, and resolves the

---
 rtl/id_ex_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: decodes ALU control, resolves the operand-2 mux and
// buffers up to two decoded instructions in an OUT/SKID pair so that EX can
// stall without a combinational ready path back into ID.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_W-1:0]     rs1_data_i,
  input  logic [DATA_W-1:0]     rs2_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic                  ALUSrc_i,
  input  logic [1:0]            ALUOp_i,
  input  logic [9:0]            funct_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  RegWrite_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic                  MemtoReg_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_W-1:0]     data1_o,
  output logic [DATA_W-1:0]     data2_o,
  output logic [2:0]            ALUCtrl_o,
  output logic [DATA_W-1:0]     rs2_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  RegWrite_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic                  MemtoReg_o
);

  localparam logic [2:0] CTRL_PASS = 3'b000;
  localparam logic [2:0] CTRL_SUM  = 3'b001;
  localparam logic [2:0] CTRL_SUB  = 3'b010;
  localparam logic [2:0] CTRL_AND  = 3'b011;
  localparam logic [2:0] CTRL_OR   = 3'b100;
  localparam logic [2:0] CTRL_XOR  = 3'b101;
  localparam logic [2:0] CTRL_MUL  = 3'b110;

  typedef struct packed {
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic [2:0]            alu_ctrl;
    logic [DATA_W-1:0]     rs2_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } entry_t;

  entry_t     out_q, out_d, skid_q, skid_d, in_entry_c;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       ready_q;
  logic [2:0] alu_ctrl_c;
  logic [6:0] f7_c;
  logic [2:0] f3_c;
  logic       xfer_in_c, drain_c;

  assign f7_c = funct_i[9:3];
  assign f3_c = funct_i[2:0];

  // ALU control decode from ALUOp and {funct7, funct3}
  always_comb begin
    alu_ctrl_c = CTRL_PASS;
    case (ALUOp_i)
      2'b00: alu_ctrl_c = CTRL_SUM;
      2'b01: alu_ctrl_c = CTRL_SUB;
      2'b10: begin
        if (f7_c == 7'b0000000) begin
          case (f3_c)
            3'b000:  alu_ctrl_c = CTRL_SUM;
            3'b111:  alu_ctrl_c = CTRL_AND;
            3'b110:  alu_ctrl_c = CTRL_OR;
            3'b100:  alu_ctrl_c = CTRL_XOR;
            default: alu_ctrl_c = CTRL_PASS;
          endcase
        end else if (f7_c == 7'b0100000 && f3_c == 3'b000) begin
          alu_ctrl_c = CTRL_SUB;
        end else if (f7_c == 7'b0000001 && f3_c == 3'b000) begin
          alu_ctrl_c = CTRL_MUL;
        end
      end
      default: begin
        case (f3_c)
          3'b000:  alu_ctrl_c = CTRL_SUM;
          3'b111:  alu_ctrl_c = CTRL_AND;
          3'b110:  alu_ctrl_c = CTRL_OR;
          3'b100:  alu_ctrl_c = CTRL_XOR;
          default: alu_ctrl_c = CTRL_PASS;
        endcase
      end
    endcase
  end

  // Assemble the incoming entry with operand 2 already muxed
  always_comb begin
    in_entry_c            = '0;
    in_entry_c.data1      = rs1_data_i;
    in_entry_c.data2      = ALUSrc_i ? imm_i : rs2_data_i;
    in_entry_c.alu_ctrl   = alu_ctrl_c;
    in_entry_c.rs2_data   = rs2_data_i;
    in_entry_c.rd_addr    = rd_addr_i;
    in_entry_c.reg_write  = RegWrite_i;
    in_entry_c.mem_read   = MemRead_i;
    in_entry_c.mem_write  = MemWrite_i;
    in_entry_c.mem_to_reg = MemtoReg_i;
  end

  assign xfer_in_c = valid_i & ready_q;
  assign drain_c   = out_valid_q & ready_i;

  // Next-state for the OUT/SKID pair; SKID only fills when OUT is stalled
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain_c) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (xfer_in_c) begin
      if (!out_valid_q || drain_c) begin
        out_d       = in_entry_c;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry_c;
        skid_valid_d = 1'b1;
      end
    end else if (drain_c) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = out_valid_q;
  assign data1_o    = out_q.data1;
  assign data2_o    = out_q.data2;
  assign ALUCtrl_o  = out_q.alu_ctrl;
  assign rs2_data_o = out_q.rs2_data;
  assign rd_addr_o  = out_q.rd_addr;
  assign RegWrite_o = out_q.reg_write;
  assign MemRead_o  = out_q.mem_read;
  assign MemWrite_o = out_q.mem_write;
  assign MemtoReg_o = out_q.mem_to_reg;

endmodule
